pc_fetch_unit: RTL and testbench



---
 rtl/fetch_pkg.sv | 41 ++++
 rtl/pc_next_mux.sv | 39 +++
 rtl/pc_fetch_unit.sv | 121 ++++++++++++
 tb/tb_pc_fetch_unit.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the PC / instruction-fetch stage.
// Optional misaligned-target trap is enabled with `define PC_MISALIGN_TRAP_EN.
package fetch_pkg;

    localparam int unsigned XLEN_W = 32;
    localparam int unsigned SRC_W  = 3;

    typedef enum logic [SRC_W-1:0] {
        PC_SRC_PLUS4  = 3'd0,
        PC_SRC_JALR   = 3'd1,
        PC_SRC_BRANCH = 3'd2,
        PC_SRC_JAL    = 3'd3,
        PC_SRC_MTVEC  = 3'd4,
        PC_SRC_MEPC   = 3'd5
    } pc_src_t;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        READY = 2'd2
    } fetch_state_t;

    // Candidate redirect targets presented by the branch address generator and CSR file.
    typedef struct packed {
        logic [XLEN_W-1:0] jal;
        logic [XLEN_W-1:0] jalr;
        logic [XLEN_W-1:0] branch;
        logic [XLEN_W-1:0] mtvec;
        logic [XLEN_W-1:0] mepc;
    } pc_targets_t;

    localparam logic [XLEN_W-1:0] NOP_INSTR  = 32'h0000_0013;
    localparam logic [XLEN_W-1:0] PC_INC     = 32'd4;
    localparam logic [XLEN_W-1:0] WORD_MASK  = 32'hFFFF_FFFC;

    // RV32I jalr: target bit 0 is discarded.
    function automatic logic [XLEN_W-1:0] clear_lsb(input logic [XLEN_W-1:0] a);
        return {a[XLEN_W-1:1], 1'b0};
    endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-PC selection with jalr LSB masking and word alignment.
// With PC_MISALIGN_TRAP_EN the raw target is passed through and flagged; otherwise it is word-aligned.
module pc_next_mux
    import fetch_pkg::*;
(
    input  logic [XLEN_W-1:0] pc,
    input  logic [SRC_W-1:0]  pc_source,
    input  pc_targets_t       targets,
    output logic [XLEN_W-1:0] pc_plus4,
    output logic [XLEN_W-1:0] next_pc,
    output logic              misaligned
);

    logic [XLEN_W-1:0] raw_target;

    always_comb begin
        pc_plus4   = pc + PC_INC;
        raw_target = pc_plus4;
        // Encodings 6 and 7 fall through to sequential flow.
        case (pc_source)
            PC_SRC_PLUS4:  raw_target = pc_plus4;
            PC_SRC_JALR:   raw_target = clear_lsb(targets.jalr);
            PC_SRC_BRANCH: raw_target = targets.branch;
            PC_SRC_JAL:    raw_target = targets.jal;
            PC_SRC_MTVEC:  raw_target = targets.mtvec;
            PC_SRC_MEPC:   raw_target = targets.mepc;
            default:       raw_target = pc_plus4;
        endcase
    end

`ifdef PC_MISALIGN_TRAP_EN
    assign next_pc    = raw_target;
    assign misaligned = |raw_target[1:0];
`else
    assign next_pc    = raw_target & WORD_MASK;
    assign misaligned = 1'b0;
`endif

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register, next-PC commit and instruction fetch handshake (BOOT -> FETCH -> READY).
// Define PC_MISALIGN_TRAP_EN to add the MISALIGN / MISALIGN_ADDR trap outputs.
module pc_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter int unsigned XLEN      = 32
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            PC_WRITE,
    input  logic [2:0]      PC_SOURCE,
    input  logic [XLEN-1:0] JAL,
    input  logic [XLEN-1:0] JALR,
    input  logic [XLEN-1:0] BRANCH,
    input  logic [XLEN-1:0] MTVEC,
    input  logic [XLEN-1:0] MEPC,
    input  logic            IMEM_ACK,
    input  logic [XLEN-1:0] IMEM_RDATA,
    output logic            IMEM_REQ,
    output logic [XLEN-1:0] IMEM_ADDR,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] PC_PLUS4,
    output logic [XLEN-1:0] IR,
`ifdef PC_MISALIGN_TRAP_EN
    output logic            MISALIGN,
    output logic [XLEN-1:0] MISALIGN_ADDR,
`endif
    output logic            IR_VALID
);

    fetch_state_t      state, state_next;
    logic [XLEN-1:0]   pc_q;
    logic [XLEN-1:0]   ir_q;
    logic              req_q;
    logic              ir_valid_q;
    logic [XLEN-1:0]   next_pc;
    logic              misaligned;
    logic              pc_load;
    logic              ir_load;
    pc_targets_t       targets;

    assign targets = '{jal: JAL, jalr: JALR, branch: BRANCH, mtvec: MTVEC, mepc: MEPC};

    pc_next_mux u_next_mux (
        .pc         (pc_q),
        .pc_source  (PC_SOURCE),
        .targets    (targets),
        .pc_plus4   (PC_PLUS4),
        .next_pc    (next_pc),
        .misaligned (misaligned)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= BOOT;
        else     state <= state_next;
    end

    // Commits are only honoured in READY; acks only in FETCH.
    always_comb begin
        state_next = state;
        pc_load    = 1'b0;
        ir_load    = 1'b0;
        case (state)
            BOOT: state_next = FETCH;
            FETCH: begin
                if (IMEM_ACK) begin
                    ir_load    = 1'b1;
                    state_next = READY;
                end
            end
            READY: begin
                if (PC_WRITE && !misaligned) begin
                    pc_load    = 1'b1;
                    state_next = FETCH;
                end
            end
            default: state_next = BOOT;
        endcase
    end

    // Request and valid flags are registered copies of the upcoming state.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pc_q       <= RESET_VEC;
            ir_q       <= NOP_INSTR;
            req_q      <= 1'b0;
            ir_valid_q <= 1'b0;
        end else begin
            if (pc_load) pc_q <= next_pc;
            if (ir_load) ir_q <= IMEM_RDATA;
            req_q      <= (state_next == FETCH);
            ir_valid_q <= (state_next == READY);
        end
    end

`ifdef PC_MISALIGN_TRAP_EN
    logic            misalign_q;
    logic [XLEN-1:0] misalign_addr_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            misalign_q      <= 1'b0;
            misalign_addr_q <= '0;
        end else begin
            misalign_q <= (state == READY) && PC_WRITE && misaligned;
            if ((state == READY) && PC_WRITE && misaligned) misalign_addr_q <= next_pc;
        end
    end

    assign MISALIGN      = misalign_q;
    assign MISALIGN_ADDR = misalign_addr_q;
`endif

    assign PC        = pc_q;
    assign IMEM_ADDR = pc_q;
    assign IMEM_REQ  = req_q;
    assign IR        = ir_q;
    assign IR_VALID  = ir_valid_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Randomized self-checking bench for pc_fetch_unit against a transaction-level PC model.
// Follows PC_MISALIGN_TRAP_EN the same way the design does.
module tb_pc_fetch_unit;

    localparam logic [31:0] RST_VEC = 32'h0000_0000;
    localparam logic [31:0] NOP     = 32'h0000_0013;

    logic        CLK, RST, PC_WRITE, IMEM_ACK;
    logic [2:0]  PC_SOURCE;
    logic [31:0] JAL, JALR, BRANCH, MTVEC, MEPC, IMEM_RDATA;
    logic        IMEM_REQ, IR_VALID;
    logic [31:0] IMEM_ADDR, PC, PC_PLUS4, IR;
`ifdef PC_MISALIGN_TRAP_EN
    logic        MISALIGN;
    logic [31:0] MISALIGN_ADDR;
`endif

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] m_pc;
    bit          trapped;

    pc_fetch_unit #(.RESET_VEC(RST_VEC), .XLEN(32)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .PC_WRITE      (PC_WRITE),
        .PC_SOURCE     (PC_SOURCE),
        .JAL           (JAL),
        .JALR          (JALR),
        .BRANCH        (BRANCH),
        .MTVEC         (MTVEC),
        .MEPC          (MEPC),
        .IMEM_ACK      (IMEM_ACK),
        .IMEM_RDATA    (IMEM_RDATA),
        .IMEM_REQ      (IMEM_REQ),
        .IMEM_ADDR     (IMEM_ADDR),
        .PC            (PC),
        .PC_PLUS4      (PC_PLUS4),
        .IR            (IR),
`ifdef PC_MISALIGN_TRAP_EN
        .MISALIGN      (MISALIGN),
        .MISALIGN_ADDR (MISALIGN_ADDR),
`endif
        .IR_VALID      (IR_VALID)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Architectural next-PC rule: chosen target, jalr LSB dropped, word-aligned unless trapping.
    function automatic logic [31:0] model_next(input logic [2:0] src, input logic [31:0] pc,
                                               input logic [31:0] jal, input logic [31:0] jalr,
                                               input logic [31:0] br, input logic [31:0] mtvec,
                                               input logic [31:0] mepc);
        logic [31:0] t;
        case (src)
            3'd1:    t = jalr - (jalr % 2);
            3'd2:    t = br;
            3'd3:    t = jal;
            3'd4:    t = mtvec;
            3'd5:    t = mepc;
            default: t = pc + 32'd4;
        endcase
`ifndef PC_MISALIGN_TRAP_EN
        t = t - (t % 4);
`endif
        return t;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Complete an outstanding fetch after 'delay' idle cycles; optionally poke PC_WRITE meanwhile.
    task automatic fetch(input int delay, input logic [31:0] data, input bit poke);
        check("fetch_req", 32'(IMEM_REQ), 32'd1);
        check("fetch_addr", IMEM_ADDR, m_pc);
        for (int i = 0; i < delay; i++) begin
            IMEM_ACK  = 1'b0;
            PC_WRITE  = poke && (i == 0);
            PC_SOURCE = 3'(($urandom_range(1, 5)));
            JAL = $urandom; JALR = $urandom; BRANCH = $urandom; MTVEC = $urandom; MEPC = $urandom;
            tick();
            PC_WRITE = 1'b0;
            check("wait_req", 32'(IMEM_REQ), 32'd1);
            check("wait_addr", IMEM_ADDR, m_pc);
            check("wait_pc", PC, m_pc);
            check("wait_valid", 32'(IR_VALID), 32'd0);
        end
        IMEM_ACK   = 1'b1;
        IMEM_RDATA = data;
        tick();
        IMEM_ACK   = 1'b0;
        IMEM_RDATA = $urandom;
        check("ready_ir", IR, data);
        check("ready_valid", 32'(IR_VALID), 32'd1);
        check("ready_req", 32'(IMEM_REQ), 32'd0);
        check("ready_pc", PC, m_pc);
    endtask

    task automatic commit(input logic [2:0] src, input logic [31:0] jal, input logic [31:0] jalr,
                          input logic [31:0] br, input logic [31:0] mtvec, input logic [31:0] mepc,
                          output bit trap);
        logic [31:0] exp;
        bit          mis;
        PC_SOURCE = src; JAL = jal; JALR = jalr; BRANCH = br; MTVEC = mtvec; MEPC = mepc;
        #1;
        check("pc_plus4", PC_PLUS4, m_pc + 32'd4);
        exp = model_next(src, m_pc, jal, jalr, br, mtvec, mepc);
        mis = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
        mis = (exp % 4) != 0;
`endif
        PC_WRITE = 1'b1;
        tick();
        PC_WRITE = 1'b0;
        trap = mis;
        if (mis) begin
`ifdef PC_MISALIGN_TRAP_EN
            check("trap_pc_hold", PC, m_pc);
            check("trap_pulse", 32'(MISALIGN), 32'd1);
            check("trap_addr", MISALIGN_ADDR, exp);
            check("trap_valid", 32'(IR_VALID), 32'd1);
            check("trap_req", 32'(IMEM_REQ), 32'd0);
            tick();
            check("trap_pulse_end", 32'(MISALIGN), 32'd0);
            check("trap_addr_hold", MISALIGN_ADDR, exp);
`endif
        end else begin
            m_pc = exp;
            check("commit_pc", PC, m_pc);
            check("commit_valid", 32'(IR_VALID), 32'd0);
            check("commit_req", 32'(IMEM_REQ), 32'd1);
        end
    endtask

    initial begin
        RST = 1'b0; PC_WRITE = 1'b0; IMEM_ACK = 1'b0; PC_SOURCE = 3'd0;
        JAL = '0; JALR = '0; BRANCH = '0; MTVEC = '0; MEPC = '0; IMEM_RDATA = '0;
        #2 RST = 1'b1;
        #1;
        check("rst_pc", PC, RST_VEC);
        check("rst_addr", IMEM_ADDR, RST_VEC);
        check("rst_req", 32'(IMEM_REQ), 32'd0);
        check("rst_ir", IR, NOP);
        check("rst_valid", 32'(IR_VALID), 32'd0);
        @(negedge CLK);
        @(negedge CLK);
        RST  = 1'b0;
        m_pc = RST_VEC;
        tick();
        check("boot_ir", IR, NOP);
        check("boot_valid", 32'(IR_VALID), 32'd0);
        fetch(0, 32'h0050_0093, 1'b0);

        // Directed redirects and boundaries.
        commit(3'd3, 32'h100, '0, '0, '0, '0, trapped);
        fetch(1, $urandom, 1'b0);
        commit(3'd0, '0, '0, '0, '0, '0, trapped);
        check("seq_pc", PC, 32'h104);
        fetch(3, $urandom, 1'b1);
        commit(3'd1, '0, 32'h0000_2001, '0, '0, '0, trapped);
        check("jalr_pc", PC, 32'h2000);
        fetch(0, $urandom, 1'b0);
        commit(3'd3, 32'h80, '0, '0, '0, '0, trapped);
        check("jal_pc", PC, 32'h80);
        fetch(2, $urandom, 1'b1);
        commit(3'd2, '0, '0, 32'h40, '0, '0, trapped);
        check("branch_pc", PC, 32'h40);
        fetch(0, $urandom, 1'b0);
        commit(3'd3, 32'hFFFF_FFFC, '0, '0, '0, '0, trapped);
        fetch(0, $urandom, 1'b0);
        check("wrap_plus4", PC_PLUS4, 32'h0);
        commit(3'd0, '0, '0, '0, '0, '0, trapped);
        check("wrap_pc", PC, 32'h0);
        fetch(1, $urandom, 1'b0);
        commit(3'd7, '0, '0, '0, '0, '0, trapped);
        check("src7_pc", PC, 32'h4);
        fetch(0, $urandom, 1'b0);
        commit(3'd3, 32'h100, '0, '0, '0, '0, trapped);
        fetch(0, $urandom, 1'b0);
        commit(3'd2, '0, '0, 32'h102, '0, '0, trapped);
        if (trapped) begin
            commit(3'd4, '0, '0, '0, 32'h200, '0, trapped);
            check("redirect_pc", PC, 32'h200);
        end else begin
            check("align_pc", PC, 32'h100);
        end
        fetch(0, $urandom, 1'b0);

        // Randomized transactions.
        for (int n = 0; n < 60; n++) begin
            commit(3'($urandom_range(0, 7)), $urandom, $urandom, $urandom, $urandom, $urandom, trapped);
            if (trapped)
                commit(3'd4, '0, '0, '0, $urandom & 32'hFFFF_FFFC, '0, trapped);
            fetch($urandom_range(0, 3), $urandom, 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of a fetch, then a stale ack while booting.
        commit(3'd0, '0, '0, '0, '0, '0, trapped);
        IMEM_ACK = 1'b0;
        @(posedge CLK);
        #3 RST = 1'b1;
        #1;
        check("mid_rst_pc", PC, RST_VEC);
        check("mid_rst_req", 32'(IMEM_REQ), 32'd0);
        check("mid_rst_ir", IR, NOP);
        check("mid_rst_valid", 32'(IR_VALID), 32'd0);
        IMEM_ACK   = 1'b1;
        IMEM_RDATA = 32'hDEAD_BEEF;
        @(negedge CLK);
        RST  = 1'b0;
        m_pc = RST_VEC;
        tick();
        IMEM_ACK = 1'b0;
        check("stale_ack_ir", IR, NOP);
        check("stale_ack_valid", 32'(IR_VALID), 32'd0);
        fetch(1, 32'h0010_0073, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
